word_uart_serializer: RTL and testbench
=======================================

Name: word_uart_serializer

Overview:
- Buffers wide result words (e.g. 128-bit hashes from the validator) and streams them byte-by-byte into the UART wrapper's tx valid/ready port.
- Parametrised successor to the fixed point-to-point result path: configurable word width, FIFO depth and terminator, drop accounting, and optional ASCII-hex framing.
- Sits in the clk domain between the result producer and uart_wrapper.

Parameters:
- DATA_W, 128, input word width; multiple of 8, range 8..512.
- DEPTH, 4, FIFO depth in words; power of 2, >= 2.
- MSB_FIRST, 1, 1 = most significant byte sent first; 0 = least significant byte first.
- TERM_EN, 1, 1 = append TERM_CHAR after each word.
- TERM_CHAR, 8'h0A, terminator byte.
- DROP_W, 16, width of the drop counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_data  in  DATA_W  result word
- in_valid  in  1  one-cycle word strobe; there is no ready, producer never stalls
- tx_data  out  8  byte to UART
- tx_valid  out  1  byte valid
- tx_ready  in  1  UART accepts byte
- fifo_level  out  $clog2(DEPTH)+1  words currently queued
- drop_cnt  out  DROP_W  saturating count of dropped words
- overflow  out  1  one-cycle pulse when a word is dropped
- busy  out  1  high while the FSM is not IDLE or the FIFO is non-empty

Behaviour:
- Reset values: tx_valid=0, tx_data=0, fifo_level=0, drop_cnt=0, overflow=0, busy=0, FSM=IDLE. Reset is synchronous, so all of these take effect at the first clk edge with reset high.
- Reset mid-word: the partial word and all queued words are discarded, tx_valid is 0 from the next cycle, and no terminator is sent.
- Write rule:
  - in_valid is accepted if level < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped: overflow pulses and drop_cnt increments, saturating at all-ones.
- FIFO order is strict first-in first-out.
- FSM states IDLE, SEND, TERM:
  - IDLE:
    - If the FIFO is non-empty, pop the head into the shift register, set byte index to 0, and go to SEND.
    - The pop happens on the IDLE->SEND edge.
  - SEND:
    - tx_valid=1; tx_data is the current byte (chosen per MSB_FIRST).
    - On tx_valid && tx_ready, advance the index.
    - After handshaking the last byte (index NB-1), go to TERM if TERM_EN, else IDLE.
    - NB = DATA_W/8, or 2*DATA_W/8 in hex mode.
  - TERM: tx_valid=1, tx_data=TERM_CHAR; on handshake go to IDLE.
- Latency:
  - A word accepted at cycle 0 into an empty FIFO with the FSM in IDLE: level=1 at cycle 1, first tx_valid at cycle 2.
  - Back-to-back throughput: IDLE costs one cycle per word, so a word takes NB + TERM_EN + 1 cycles at tx_ready=1.
- AXI-style output rules:
  - tx_data is stable while tx_valid && !tx_ready.
  - tx_valid never falls without a handshake, except on reset.
  - tx_valid does not depend combinationally on tx_ready.
- Simultaneous write and pop with the FIFO full: the write is accepted and the level stays at DEPTH.
- Pointer wrap: the pointers carry $clog2(DEPTH) bits and wrap naturally; fifo_level is a separate counter.

Optional Feature:
- Macro: WORD_UART_SERIALIZER_HEX_ASCII_EN.
- Defined:
  - Each data byte is emitted as two uppercase ASCII hex characters, high nibble first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46).
  - Nibble order follows MSB_FIRST at byte granularity.
  - The terminator is still raw TERM_CHAR.
- Undefined: raw binary bytes; the nibble-conversion logic is absent.

Decomposition:
- Package/include word_uart_pkg:
  - FSM state encodings (IDLE=2'd0, SEND=2'd1, TERM=2'd2).
  - ASCII constants ASCII_0=8'h30, ASCII_A=8'h41.
  - Function nibble_to_ascii.
- Sub-module sync_fifo:
  - Parameters WIDTH, DEPTH.
  - Ports wr_en, wr_data, rd_en, rd_data, full, empty, level.
  - Same clk and synchronous reset.
- The FSM, shift logic and drop counter stay in word_uart_serializer.

Test Plan:
- Basic order: defaults; in_valid with in_data=128'h00112233445566778899AABBCCDDEEFF, tx_ready=1 -> bytes 00,11,...,FF,0A (17 handshakes), first tx_valid 2 cycles after in_valid, busy falls after the 0A byte.
- Backpressure: same word, tx_ready pseudo-random 30% -> identical byte sequence; tx_data/tx_valid held stable on every stalled cycle.
- Overflow: DEPTH=4, tx_ready=0, 6 consecutive in_valid words W0..W5 -> FIFO path holds W1..W4 (W0 already in the shift register), W5 dropped, drop_cnt=1, one overflow pulse, fifo_level=4. Release tx_ready -> W0..W4 emitted in order.
- Saturation: DROP_W=4, FIFO full, 20 dropped words -> drop_cnt=15 and stays at 15.
- Reset mid-word: reset asserted after the 5th byte of W0 with W1 queued -> tx_valid=0 and fifo_level=0 the next cycle. A new word W2 is then emitted complete from byte 0.
- Hex mode (macro defined, DATA_W=16, MSB_FIRST=0): word 16'hA51F -> "1","F","A","5",0x0A.

Source files
------------

// File: rtl/word_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : word_uart_pkg
//  Brief    : Shared FSM encoding, ASCII constants and the nibble-to-ASCII
//             helper used by the word-to-UART serializer.
//  Revision : 1.0 - initial release
// ============================================================================
package word_uart_pkg;

    // Serializer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_TERM = 2'd2
    } state_e;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_A = 8'h41;

    // Map a 4-bit value to its uppercase ASCII hex character
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'd0, nib};
        end else begin
            return ASCII_A + {4'd0, nib} - 8'd10;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/word_uart_serializer_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock FIFO with a separate occupancy counter. Pointers
//             are log2(DEPTH) bits and wrap naturally. A write while full is
//             accepted only when a read happens in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;
    logic             w_do_wr;
    logic             w_do_rd;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // When full, rd_ptr == wr_ptr: the head is read combinationally this
    // cycle and overwritten at the edge, so push-while-pop is safe.
    assign w_do_rd = rd_en && !empty;
    assign w_do_wr = wr_en && (!full || w_do_rd);

    // Next-state for pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_do_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({w_do_wr, w_do_rd})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/word_uart_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : word_uart_serializer
//  Brief    : Queues wide result words and streams them byte-by-byte onto a
//             valid/ready UART transmit port, with optional terminator byte,
//             saturating drop accounting and overflow pulse.
//  Options  : WORD_UART_SERIALIZER_HEX_ASCII_EN - emit each data byte as two
//             uppercase ASCII hex characters (terminator stays raw).
//  Revision : 1.0 - initial release
// ============================================================================
module word_uart_serializer
    import word_uart_pkg::*;
#(
    parameter int         DATA_W    = 128,
    parameter int         DEPTH     = 4,
    parameter int         MSB_FIRST = 1,
    parameter int         TERM_EN   = 1,
    parameter logic [7:0] TERM_CHAR = 8'h0A,
    parameter int         DROP_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic                     overflow,
    output logic                     busy
);

    localparam int NBYTES = DATA_W / 8;
`ifdef WORD_UART_SERIALIZER_HEX_ASCII_EN
    localparam int NB     = 2 * NBYTES;
`else
    localparam int NB     = NBYTES;
`endif
    localparam int IDX_W  = (NB > 1) ? $clog2(NB) : 1;

    state_e              state_q,    state_d;
    logic [DATA_W-1:0]   shreg_q,    shreg_d;
    logic [IDX_W-1:0]    idx_q,      idx_d;
    logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic                overflow_q, overflow_d;

    logic                w_pop;
    logic                w_accept;
    logic                w_drop;
    logic [DATA_W-1:0]   w_fifo_rd_data;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [7:0]          w_cur_byte;
    logic [DATA_W-1:0]   w_shreg_shifted;
    logic [7:0]          w_char;
    logic                w_byte_done;

    // The head is popped on the IDLE->SEND transition
    assign w_pop    = (state_q == ST_IDLE) && !w_fifo_empty;
    assign w_accept = in_valid && (!w_fifo_full || w_pop);
    assign w_drop   = in_valid && !w_accept;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_accept),
        .wr_data (in_data),
        .rd_en   (w_pop),
        .rd_data (w_fifo_rd_data),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .level   (fifo_level)
    );

    // Current byte sits at the outgoing end of the shift register
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_cur_byte      = shreg_q[DATA_W-1 -: 8];
            assign w_shreg_shifted = shreg_q << 8;
        end else begin : g_lsb_first
            assign w_cur_byte      = shreg_q[7:0];
            assign w_shreg_shifted = shreg_q >> 8;
        end
    endgenerate

`ifdef WORD_UART_SERIALIZER_HEX_ASCII_EN
    // Even index sends the high nibble, odd index the low nibble and frees the byte
    assign w_byte_done = idx_q[0];
    assign w_char      = idx_q[0] ? nibble_to_ascii(w_cur_byte[3:0])
                                  : nibble_to_ascii(w_cur_byte[7:4]);
`else
    assign w_byte_done = 1'b1;
    assign w_char      = w_cur_byte;
`endif

    // Serializer FSM next-state and transmit outputs
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    shreg_d = w_fifo_rd_data;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = w_char;
                if (tx_ready) begin
                    if (w_byte_done) begin
                        shreg_d = w_shreg_shifted;
                    end
                    if (idx_q == IDX_W'(NB - 1)) begin
                        idx_d   = '0;
                        state_d = (TERM_EN != 0) ? ST_TERM : ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_TERM: begin
                tx_valid = 1'b1;
                tx_data  = TERM_CHAR;
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating drop counter and overflow pulse
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        overflow_d = w_drop;
        if (w_drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
    end

    // State, shift register and accounting registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            idx_q      <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != ST_IDLE) || !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_word_uart_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_word_uart_serializer
//  Brief    : Directed self-checking bench for word_uart_serializer: byte
//             order, backpressure stability, overflow/drop accounting,
//             saturation, LSB-first / hex framing and mid-word reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_word_uart_serializer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Main instance: default parameters
    logic [127:0] in_data  = '0;
    logic         in_valid = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic [2:0]   fifo_level;
    logic [15:0]  drop_cnt;
    logic         overflow;
    logic         busy;

    // Saturation instance: byte words, 4-bit drop counter, no terminator
    logic [7:0]   d1_in_data  = '0;
    logic         d1_in_valid = 1'b0;
    logic [7:0]   d1_tx_data;
    logic         d1_tx_valid;
    logic         d1_tx_ready = 1'b0;
    logic [2:0]   d1_level;
    logic [3:0]   d1_drop;
    logic         d1_overflow;
    logic         d1_busy;

    // LSB-first instance: 16-bit words
    logic [15:0]  d2_in_data  = '0;
    logic         d2_in_valid = 1'b0;
    logic [7:0]   d2_tx_data;
    logic         d2_tx_valid;
    logic         d2_tx_ready = 1'b0;
    logic [2:0]   d2_level;
    logic [15:0]  d2_drop;
    logic         d2_overflow;
    logic         d2_busy;

    word_uart_serializer u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .fifo_level(fifo_level), .drop_cnt(drop_cnt), .overflow(overflow), .busy(busy)
    );

    word_uart_serializer #(.DATA_W(8), .DEPTH(4), .TERM_EN(0), .DROP_W(4)) u_dut_sat (
        .clk(clk), .reset(reset), .in_data(d1_in_data), .in_valid(d1_in_valid),
        .tx_data(d1_tx_data), .tx_valid(d1_tx_valid), .tx_ready(d1_tx_ready),
        .fifo_level(d1_level), .drop_cnt(d1_drop), .overflow(d1_overflow), .busy(d1_busy)
    );

    word_uart_serializer #(.DATA_W(16), .MSB_FIRST(0)) u_dut_lsb (
        .clk(clk), .reset(reset), .in_data(d2_in_data), .in_valid(d2_in_valid),
        .tx_data(d2_tx_data), .tx_valid(d2_tx_valid), .tx_ready(d2_tx_ready),
        .fifo_level(d2_level), .drop_cnt(d2_drop), .overflow(d2_overflow), .busy(d2_busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
    endfunction

    // Expected on-wire image of one byte
    task automatic push_byte(input logic [7:0] b);
`ifdef WORD_UART_SERIALIZER_HEX_ASCII_EN
        exp_q.push_back(hex_char(b[7:4]));
        exp_q.push_back(hex_char(b[3:0]));
`else
        exp_q.push_back(b);
`endif
    endtask

    // Expected stream for one 128-bit word on the main instance (MSB first + LF)
    task automatic push_word(input logic [127:0] w);
        for (int i = 15; i >= 0; i--) push_byte(w[i*8 +: 8]);
        exp_q.push_back(8'h0A);
    endtask

    // Drain main instance against exp_q with tx_ready asserted ready_pct% of cycles
    task automatic drain_main(input int ready_pct, input int budget);
        logic       stalled = 1'b0;
        logic [7:0] held = 8'h00;
        int         cyc = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            if (stalled) begin
                check_value("stall_valid", tx_valid, 1'b1);
                check_value("stall_data", tx_data, held);
            end
            tx_ready = ($urandom_range(0, 99) < ready_pct);
            if (tx_valid && tx_ready) begin
                check_value("byte", tx_data, exp_q.pop_front());
                stalled = 1'b0;
            end else begin
                stalled = tx_valid;
                held    = tx_data;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check_value("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    function automatic logic [127:0] ovf_word(input int k);
        return {8{8'hC0 + 8'(k), 8'h5A}};
    endfunction

    initial begin
        logic [127:0] w;
        int cyc;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_tx_valid", tx_valid, 1'b0);
        check_value("rst_tx_data", tx_data, 8'h00);
        check_value("rst_level", fifo_level, 3'd0);
        check_value("rst_drop", drop_cnt, 16'd0);
        check_value("rst_overflow", overflow, 1'b0);
        check_value("rst_busy", busy, 1'b0);
        reset = 1'b0;

        // Basic order and latency
        w = 128'h00112233445566778899AABBCCDDEEFF;
        in_data = w; in_valid = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_value("lat_level1", fifo_level, 3'd1);
        check_value("lat_valid_c1", tx_valid, 1'b0);
        check_value("lat_busy", busy, 1'b1);
        @(posedge clk); #1;
        check_value("lat_valid_c2", tx_valid, 1'b1);
        push_word(w);
        drain_main(100, 200);
        check_value("basic_busy_end", busy, 1'b0);

        // Backpressure: same word, ~30% ready
        tx_ready = 1'b0;
        in_data = w; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        push_word(w);
        drain_main(30, 3000);
        check_value("bp_busy_end", busy, 1'b0);

        // Overflow: six words with tx_ready low
        tx_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_data = ovf_word(k); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_value("ovf_pulse", overflow, 1'b1);
        check_value("ovf_drop", drop_cnt, 16'd1);
        check_value("ovf_level", fifo_level, 3'd4);
        @(posedge clk); #1;
        check_value("ovf_pulse_end", overflow, 1'b0);
        check_value("ovf_held_valid", tx_valid, 1'b1);
        for (int k = 0; k < 5; k++) push_word(ovf_word(k));
        drain_main(100, 500);
        check_value("ovf_busy_end", busy, 1'b0);
        check_value("ovf_drop_end", drop_cnt, 16'd1);

        // Saturation: 8-bit words, 4-bit counter, 20 drops then 3 more
        d1_tx_ready = 1'b0;
        for (int k = 0; k < 25; k++) begin
            d1_in_data = 8'h40 + 8'(k); d1_in_valid = 1'b1;
            @(posedge clk); #1;
        end
        check_value("sat_drop15", d1_drop, 4'd15);
        check_value("sat_level", d1_level, 3'd4);
        check_value("sat_overflow", d1_overflow, 1'b1);
        for (int k = 0; k < 3; k++) begin
            d1_in_data = 8'hEE; @(posedge clk); #1;
        end
        d1_in_valid = 1'b0;
        check_value("sat_hold15", d1_drop, 4'd15);
        for (int k = 0; k < 5; k++) push_byte(8'h40 + 8'(k));
        d1_tx_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            if (d1_tx_valid) check_value("sat_byte", d1_tx_data, exp_q.pop_front());
            @(posedge clk); #1;
            cyc++;
        end
        check_value("sat_drain_left", exp_q.size(), 0);
        exp_q.delete();
        check_value("sat_busy_end", d1_busy, 1'b0);

        // LSB-first 16-bit word
        d2_tx_ready = 1'b1;
        d2_in_data = 16'hA51F; d2_in_valid = 1'b1;
        @(posedge clk); #1;
        d2_in_valid = 1'b0;
        push_byte(8'h1F);
        push_byte(8'hA5);
        exp_q.push_back(8'h0A);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            if (d2_tx_valid) check_value("lsb_byte", d2_tx_data, exp_q.pop_front());
            @(posedge clk); #1;
            cyc++;
        end
        check_value("lsb_drain_left", exp_q.size(), 0);
        exp_q.delete();

        // Reset mid-word with a second word queued
        tx_ready = 1'b1;
        in_data = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F; in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_value("mid_valid_start", tx_valid, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check_value("mid_queued", fifo_level, 3'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_value("mid_rst_valid", tx_valid, 1'b0);
        check_value("mid_rst_level", fifo_level, 3'd0);
        check_value("mid_rst_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_value("mid_no_resume", tx_valid, 1'b0);
        w = 128'h0123456789ABCDEFFEDCBA9876543210;
        in_data = w; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        push_word(w);
        drain_main(100, 200);
        check_value("mid_busy_end", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
